// File: rtl/shared_mem_arbiter.sv
// Two-requester (IF/MEM) arbiter for a fixed-latency single-ported memory bus.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants under contention.
module shared_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic              bus_en,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_IF,
    G_MEM
  } gnt_t;

  state_t            state_q;
  gnt_t              gnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              bus_en_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_ready_q;
  logic              mem_ready_q;

  logic mem_pend;
  logic pick_mem_d;

  assign mem_pend = mem_rd_req | mem_wr_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_mem_q;

  // Under contention the requester not served last wins
  always_comb begin
    pick_mem_d = mem_pend & (~if_req | ~last_mem_q);
  end

  // Remember which side got the most recent grant (reset: IF)
  always_ff @(posedge clk) begin
    if (rst) begin
      last_mem_q <= 1'b0;
    end else if (state_q == S_IDLE && (mem_pend || if_req)) begin
      last_mem_q <= pick_mem_d;
    end
  end
`else
  // Fixed priority: MEM always beats IF
  always_comb begin
    pick_mem_d = mem_pend;
  end
`endif

  // Access sequencer: grant, hold bus for WAIT_CYCLES, pulse ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= G_NONE;
      cnt_q       <= '0;
      bus_en_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (mem_pend || if_req) begin
            state_q  <= S_BUSY;
            cnt_q    <= CNT_INIT;
            bus_en_q <= 1'b1;
            if (pick_mem_d) begin
              gnt_q       <= G_MEM;
              bus_addr_q  <= mem_addr;
              bus_wdata_q <= mem_wdata;
              bus_we_q    <= mem_wr_req;
            end else begin
              gnt_q       <= G_IF;
              bus_addr_q  <= if_addr;
              bus_wdata_q <= '0;
              bus_we_q    <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q  <= S_DONE;
            bus_en_q <= 1'b0;
            bus_we_q <= 1'b0;
            if (!bus_we_q) begin
              if (gnt_q == G_IF) if_rdata_q <= bus_rdata;
              if (gnt_q == G_MEM) mem_rdata_q <= bus_rdata;
            end
            if_ready_q  <= (gnt_q == G_IF);
            mem_ready_q <= (gnt_q == G_MEM);
          end
        end
        S_DONE: begin
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          gnt_q       <= G_NONE;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_en    = bus_en_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;

  assign freeze = (if_req & ~if_ready_q) | (mem_pend & ~mem_ready_q);

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Sequences a single, fixed-latency, single-ported memory bus that is shared by two requesters.
- Requester 1 is the IF stage (instruction fetch, read-only). Requester 2 is the MEM stage (data read/write).
- Grants one requester at a time, holds the bus for WAIT_CYCLES, and returns read data plus a one-cycle ready pulse.
- Drives a freeze output that stalls the pipeline while any request is outstanding.

Parameters:
- ADDR_W, 32, address width of requesters and bus.
- DATA_W, 32, data width of requesters and bus.
- WAIT_CYCLES, 4, cycles the bus is held per access; legal range is >=1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- if_req  input  1  IF read request (level; held until if_ready)
- if_addr  input  ADDR_W  IF read address
- if_rdata  output  DATA_W  last instruction word returned to IF
- if_ready  output  1  one-cycle pulse: IF access complete, if_rdata valid
- mem_rd_req  input  1  MEM read request (level)
- mem_wr_req  input  1  MEM write request (level)
- mem_addr  input  ADDR_W  MEM address
- mem_wdata  input  DATA_W  MEM write data
- mem_rdata  output  DATA_W  last data word read for MEM
- mem_ready  output  1  one-cycle pulse: MEM access complete
- freeze  output  1  pipeline stall: some request is pending and not completing this cycle
- bus_en  output  1  memory bus access active
- bus_we  output  1  memory bus write enable
- bus_addr  output  ADDR_W  memory bus address
- bus_wdata  output  DATA_W  memory bus write data
- bus_rdata  input  DATA_W  memory bus read data; valid in the last BUSY cycle

Behaviour:
- Reset values: state IDLE; if_ready, mem_ready, bus_en, bus_we = 0; bus_addr, bus_wdata, if_rdata, mem_rdata = 0; grant = none; counter = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If mem_rd_req|mem_wr_req, grant MEM. Otherwise if if_req, grant IF. Otherwise stay in IDLE.
  - On grant, latch addr, wdata and we into bus registers. we = mem_wr_req (MEM) or 0 (IF).
  - On grant, set counter = WAIT_CYCLES-1 and go to BUSY.
- BUSY:
  - bus_en=1. bus_addr, bus_wdata and bus_we come from the latched registers and stay stable for the whole access.
  - Decrement counter while counter!=0.
  - When counter==0: for a read grant, capture bus_rdata into the granted requester's rdata register; go to DONE.
- DONE:
  - bus_en=0, bus_we=0.
  - Pulse the granted requester's ready for exactly this cycle; clear grant; go to IDLE.
- Latency: from request seen in IDLE to ready = WAIT_CYCLES+1 cycles. The bus is free one cycle after DONE, so back-to-back accesses occupy WAIT_CYCLES+2 cycles each.
- A request still asserted in IDLE after its ready is served as a new access. The requester must drop or change its request on the cycle after ready; the pipeline advancing on freeze=0 does this.
- rdata registers hold their value until the next read completion for that requester. A write completion leaves mem_rdata unchanged.
- Simultaneous mem_rd_req and mem_wr_req: served as a write.
- Request dropped mid-access: the access still completes, ready still pulses, and the data is discarded by the requester.
- Request inputs changing during BUSY: ignored, because the bus registers are latched.
- freeze (combinational) = (if_req & ~if_ready) | ((mem_rd_req|mem_wr_req) & ~mem_ready).
- WAIT_CYCLES=1: BUSY lasts exactly one cycle.
- rst asserted mid-access: the next edge returns to reset values, the access is abandoned, and no ready pulse is produced.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_grant register (reset = IF) is kept. When both requesters are pending in IDLE, the requester not granted last wins; last_grant updates on every grant.
- Undefined: fixed priority, MEM over IF, with no extra state.
- With a single requester pending, behaviour is identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no requests -> all outputs 0, freeze=0, bus_en stays 0.
- IF read: WAIT_CYCLES=4, if_req=1, if_addr=0x10, memory returns 0xE3A00001 -> bus_en high for cycles 1-4, if_ready pulses in cycle 5, if_rdata=0xE3A00001, freeze=1 in cycles 0-4 and 0 in cycle 5.
- Contention: if_req and mem_rd_req (addr 0x400, data 0x55) raised together -> MEM served first (mem_ready at cycle 5, mem_rdata=0x55); IF served next (if_ready at cycle 11); freeze stays 1 through cycle 10. With ARB_ROUND_ROBIN_EN and last_grant=MEM, IF is served first.
- Write: mem_wr_req=1, mem_addr=0x8, mem_wdata=0xDEADBEEF -> bus_we=1 and bus_wdata=0xDEADBEEF for 4 cycles; mem_ready pulses; mem_rdata unchanged.
- Boundaries: WAIT_CYCLES=1 IF read -> ready at cycle 2. rd+wr together -> treated as a write. Inputs changed in BUSY -> bus_addr stays stable.
- Reset mid-access: rst=1 in cycle 2 of BUSY -> next cycle IDLE, bus_en=0, no ready pulse; a fresh request after reset completes normally.
